hazard_ctrl_v2: RTL
===================

Name: hazard_ctrl_v2

Overview:
- Parametrised pipeline hazard controller for the 5-stage core (F/D/E/MEM/WB); successor to the single-cycle forwarding/flush controller.
- Adds E-stage and D-stage forwarding select, load-use stall with bubble insertion, and a multi-cycle execute stall FSM for mul/div.
- Adds a configurable multi-cycle redirect flush window after a taken jump, for fetch paths with extra latency.
- Sits beside the pipeline registers and drives their stall and flush enables.

Parameters:
RIDX_W, 5, register index width (32 or 16 architectural registers)
MD_LAT, 4, cycles a multi-cycle op occupies E; legal range 2..255
REDIR_CYC, 1, cycles o_flush_d is held after a taken jump; legal range 1..15

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_rs1idx_d / i_rs2idx_d  in  RIDX_W  source indices of the instruction in D
i_rs1idx_e / i_rs2idx_e  in  RIDX_W  source indices of the instruction in E
i_rdidx_e, i_rdwen_e, i_rdren_e  in  RIDX_W,1,1  E destination index, write enable, is-load
i_rdidx_mem, i_rdwen_mem, i_rdren_mem  in  RIDX_W,1,1  MEM destination index, write enable, is-load
i_rdidx_wb, i_rdwen_wb  in  RIDX_W,1  WB destination index, write enable
i_md_start_e  in  1  multi-cycle op present in E
i_exu_jump  in  1  taken jump/branch resolved in E
o_fwd_rs1_e / o_fwd_rs2_e  out  2  E operand select: 00 regfile, 10 MEM, 01 WB
o_fwd_rs1_d / o_fwd_rs2_d  out  1  D compare operand from MEM result
o_stall_f, o_stall_d, o_stall_e  out  1  hold the stage register
o_flush_f, o_flush_d, o_flush_e  out  1  bubble the stage register
o_md_done  out  1  one-cycle pulse: multi-cycle op releases E
o_busy  out  1  FSM not in RUN

Behaviour:
- Reset: clock and reset as already decided (one clock i_clk; i_rst_n synchronous, active-low). While i_rst_n=0, all outputs are 0; next edge sets state RUN and cnt 0.
- Index 0 never matches. A match requires equal index and the producer's wen=1.
- E forward: MEM match -> 10, else WB match -> 01, else 00. MEM has priority.
- D forward: o_fwd_rsX_d=1 on MEM match with i_rdren_mem=0.
- Load-use (RUN only), lu=1 when either:
  - i_rdren_e=1, i_rdwen_e=1 and a nonzero D index equals i_rdidx_e; or
  - i_rdren_mem=1 and a nonzero D index equals i_rdidx_mem.
  - Effect: o_stall_f=o_stall_d=1, o_flush_e=1, combinational, same cycle.
- FSM states RUN, MD_WAIT, REDIR. cnt is 8 bits.
- RUN:
  - i_md_start_e=1 -> stall F/D/E. If MD_LAT=2, cnt<=0; else cnt<=MD_LAT-2. Go MD_WAIT. Jump and lu are ignored this cycle; md wins.
  - Else i_exu_jump=1 -> o_flush_f=o_flush_d=1 and lu is suppressed. If REDIR_CYC>1, cnt<=REDIR_CYC-2 and go REDIR; else stay RUN.
- MD_WAIT:
  - cnt!=0 -> stall F/D/E, cnt--.
  - cnt==0 -> no stall, o_md_done=1, go RUN. i_exu_jump in this cycle is handled exactly as in RUN.
  - i_md_start_e is ignored because E is held.
  - The op occupies E for exactly MD_LAT cycles (MD_LAT-1 stall cycles).
- REDIR:
  - o_flush_d=1 each cycle. cnt==0 -> go RUN, else cnt--.
  - lu, jump and md_start are ignored.
  - o_flush_d is high for REDIR_CYC consecutive cycles in total.
- o_busy=1 in MD_WAIT or REDIR.
- Forwarding outputs are active in every state.
- Reset mid-operation: abandons MD_WAIT/REDIR, no o_md_done pulse.

Optional Feature:
- HAZ_PERF_CNT_EN defined: 32-bit outputs o_stall_cycles and o_flush_events.
  - o_stall_cycles +1 each cycle o_stall_f=1.
  - o_flush_events +1 each cycle o_flush_f=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports present and tied to 0, no counter flops.

Test Plan:
- E rs1=5, MEM rd=5 wen, WB rd=5 wen -> o_fwd_rs1_e=10. Drop MEM wen -> 01. Set rs1=0 -> 00.
- E load rd=7, D rs2=7 -> one cycle of o_stall_f=o_stall_d=o_flush_e=1. Next cycle (load in MEM, i_rdren_mem=1) still stalls. Then releases.
- MD_LAT=4, i_md_start_e held -> stall_e high cycles 0-2, o_md_done at cycle 3, o_busy cycles 1-3. MD_LAT=2 -> one stall cycle, done at cycle 1.
- REDIR_CYC=3, jump pulse with load-use present -> o_flush_f 1 cycle, o_flush_d 3 cycles, no stall, o_busy 2 cycles.
- i_md_start_e and i_exu_jump same cycle -> MD_WAIT entered, no flush. Jump on done cycle -> flush_f/flush_d asserted.
- Reset in MD_WAIT at cnt=1 -> outputs 0, RUN, no o_md_done. HAZ_PERF_CNT_EN: after the MD_LAT=4 op, o_stall_cycles=3.

Source files
------------

// File: rtl/hazard_ctrl_v2.sv
// Pipeline hazard controller for the F/D/E/MEM/WB core: operand forwarding, load-use
// stall, multi-cycle execute stall and redirect flush window. Optional macro HAZ_PERF_CNT_EN.
module hazard_ctrl_v2 #(
  parameter int RIDX_W    = 5,
  parameter int MD_LAT    = 4,
  parameter int REDIR_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [RIDX_W-1:0] i_rs1idx_d,
  input  logic [RIDX_W-1:0] i_rs2idx_d,
  input  logic [RIDX_W-1:0] i_rs1idx_e,
  input  logic [RIDX_W-1:0] i_rs2idx_e,
  input  logic [RIDX_W-1:0] i_rdidx_e,
  input  logic              i_rdwen_e,
  input  logic              i_rdren_e,
  input  logic [RIDX_W-1:0] i_rdidx_mem,
  input  logic              i_rdwen_mem,
  input  logic              i_rdren_mem,
  input  logic [RIDX_W-1:0] i_rdidx_wb,
  input  logic              i_rdwen_wb,
  input  logic              i_md_start_e,
  input  logic              i_exu_jump,
  output logic [1:0]        o_fwd_rs1_e,
  output logic [1:0]        o_fwd_rs2_e,
  output logic              o_fwd_rs1_d,
  output logic              o_fwd_rs2_d,
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_stall_e,
  output logic              o_flush_f,
  output logic              o_flush_d,
  output logic              o_flush_e,
  output logic              o_md_done,
  output logic              o_busy,
  output logic [1:0]        o_state,
  output logic [31:0]       o_stall_cycles,
  output logic [31:0]       o_flush_events
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    REDIR   = 2'd2
  } state_t;

  // Counter preload values: the entry cycle itself is the first stall/flush cycle.
  localparam logic [7:0] MD_INIT    = (MD_LAT == 2) ? 8'd0 : 8'(MD_LAT - 2);
  localparam logic [7:0] REDIR_INIT = (REDIR_CYC > 1) ? 8'(REDIR_CYC - 2) : 8'd0;
  localparam bit         REDIR_MULTI = (REDIR_CYC > 1);

  state_t     state_q, state_nxt;
  logic [7:0] cnt_q, cnt_nxt;

  logic [1:0] fwd_rs1_e_c, fwd_rs2_e_c;
  logic       fwd_rs1_d_c, fwd_rs2_d_c;
  logic       stall_f_c, stall_d_c, stall_e_c;
  logic       flush_f_c, flush_d_c, flush_e_c;
  logic       md_done_c, lu;

  // Index 0 is the hardwired zero register and never produces a hazard.
  function automatic logic hit(input logic [RIDX_W-1:0] src,
                               input logic [RIDX_W-1:0] dst,
                               input logic              wen);
    return (src != '0) && wen && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [RIDX_W-1:0] src);
    if (hit(src, i_rdidx_mem, i_rdwen_mem))     return 2'b10;
    else if (hit(src, i_rdidx_wb, i_rdwen_wb))  return 2'b01;
    else                                        return 2'b00;
  endfunction

  always_comb begin
    fwd_rs1_e_c = fwd_sel(i_rs1idx_e);
    fwd_rs2_e_c = fwd_sel(i_rs2idx_e);
    fwd_rs1_d_c = hit(i_rs1idx_d, i_rdidx_mem, i_rdwen_mem) && !i_rdren_mem;
    fwd_rs2_d_c = hit(i_rs2idx_d, i_rdidx_mem, i_rdwen_mem) && !i_rdren_mem;
    // A load still in MEM blocks D regardless of its write enable.
    lu = (i_rdren_e && (hit(i_rs1idx_d, i_rdidx_e, i_rdwen_e) ||
                        hit(i_rs2idx_d, i_rdidx_e, i_rdwen_e))) ||
         (i_rdren_mem && (hit(i_rs1idx_d, i_rdidx_mem, 1'b1) ||
                          hit(i_rs2idx_d, i_rdidx_mem, 1'b1)));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    stall_f_c = 1'b0;
    stall_d_c = 1'b0;
    stall_e_c = 1'b0;
    flush_f_c = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    md_done_c = 1'b0;
    case (state_q)
      RUN: begin
        if (i_md_start_e) begin
          {stall_f_c, stall_d_c, stall_e_c} = 3'b111;
          cnt_nxt   = MD_INIT;
          state_nxt = MD_WAIT;
        end else if (i_exu_jump) begin
          flush_f_c = 1'b1;
          flush_d_c = 1'b1;
          if (REDIR_MULTI) begin
            cnt_nxt   = REDIR_INIT;
            state_nxt = REDIR;
          end
        end else if (lu) begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          flush_e_c = 1'b1;
        end
      end
      MD_WAIT: begin
        if (cnt_q != 8'd0) begin
          {stall_f_c, stall_d_c, stall_e_c} = 3'b111;
          cnt_nxt = cnt_q - 8'd1;
        end else begin
          // Release cycle: E is free again, so a jump resolving now redirects as usual.
          md_done_c = 1'b1;
          state_nxt = RUN;
          if (i_exu_jump) begin
            flush_f_c = 1'b1;
            flush_d_c = 1'b1;
            if (REDIR_MULTI) begin
              cnt_nxt   = REDIR_INIT;
              state_nxt = REDIR;
            end
          end
        end
      end
      REDIR: begin
        flush_d_c = 1'b1;
        if (cnt_q == 8'd0) state_nxt = RUN;
        else               cnt_nxt   = cnt_q - 8'd1;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Every output is forced low while reset is asserted.
  always_comb begin
    o_fwd_rs1_e = i_rst_n ? fwd_rs1_e_c : 2'b00;
    o_fwd_rs2_e = i_rst_n ? fwd_rs2_e_c : 2'b00;
    o_fwd_rs1_d = i_rst_n && fwd_rs1_d_c;
    o_fwd_rs2_d = i_rst_n && fwd_rs2_d_c;
    o_stall_f   = i_rst_n && stall_f_c;
    o_stall_d   = i_rst_n && stall_d_c;
    o_stall_e   = i_rst_n && stall_e_c;
    o_flush_f   = i_rst_n && flush_f_c;
    o_flush_d   = i_rst_n && flush_d_c;
    o_flush_e   = i_rst_n && flush_e_c;
    o_md_done   = i_rst_n && md_done_c;
    o_busy      = i_rst_n && (state_q != RUN);
    o_state     = i_rst_n ? state_q : RUN;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      if (o_stall_f && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (o_flush_f && (flush_events_q != 32'hFFFF_FFFF))
        flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_events = flush_events_q;
`else
  assign o_stall_cycles = 32'd0;
  assign o_flush_events = 32'd0;
`endif

endmodule
